ysyx_22041461_wbu: RTL and testbench

Writeback unit for the NPC core: the producer side of the general-purpose register file write port. It accepts completed instructions from the execute stage through a valid/ready handshake, waits for memory read data on loads, and formats (sign-/zero-extends) that data. It drives a registered single-port write (enable, address, data) into the register file, plus a per-register load-pending scoreboard for decode hazard checks and a retire pulse for the simulation harness.

---
 rtl/ysyx_22041461_wbu.sv | 129 ++++++++++++
 tb/tb_ysyx_22041461_wbu.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041461_wbu.sv
// rtl/ysyx_22041461_wbu.sv - NPC writeback unit: load formatting, register file write port, load-pending scoreboard
module ysyx_22041461_wbu (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [1:0]  ex_wb_sel,
  input  logic [4:0]  ex_rd,
  input  logic [63:0] ex_result,
  input  logic [2:0]  ex_ld_funct3,
  input  logic [2:0]  ex_addr_lo,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [63:0] mem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic [31:0] ld_busy,
  output logic        retire
);

  typedef enum logic {IDLE = 1'b0, WAIT_MEM = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [4:0]  r_rd;
  logic [2:0]  r_f3;
  logic [2:0]  r_alo;
  logic        r_rf_wen;
  logic [4:0]  r_rf_waddr;
  logic [63:0] r_rf_wdata;
  logic [31:0] r_ld_busy;
  logic        r_retire;

  logic        w_ex_fire;
  logic        w_ex_load;
  logic        w_mem_fire;
  logic [63:0] w_sh;
  logic [63:0] w_ld_val;
  logic [31:0] w_busy_nxt;

  assign ex_ready   = (r_state == IDLE);
  assign mem_rready = (r_state == WAIT_MEM);
  assign w_ex_fire  = ex_valid && (r_state == IDLE);
  assign w_ex_load  = (ex_wb_sel == 2'b10);
  assign w_mem_fire = mem_rvalid && (r_state == WAIT_MEM);

  // Bytes shifted in from above bit 63 are zero, which covers misaligned accesses.
  assign w_sh = mem_rdata >> {r_alo, 3'b000};

  always_comb begin
    w_ld_val = w_sh;
    case (r_f3)
      3'b000:  w_ld_val = {{56{w_sh[7]}},  w_sh[7:0]};
      3'b001:  w_ld_val = {{48{w_sh[15]}}, w_sh[15:0]};
      3'b010:  w_ld_val = {{32{w_sh[31]}}, w_sh[31:0]};
      3'b100:  w_ld_val = {56'd0, w_sh[7:0]};
      3'b101:  w_ld_val = {48'd0, w_sh[15:0]};
      3'b110:  w_ld_val = {32'd0, w_sh[31:0]};
      default: w_ld_val = w_sh;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (ex_valid && w_ex_load) w_next = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Clear for the write in flight happens first so a new load to the same rd keeps its bit.
  always_comb begin
    w_busy_nxt = r_ld_busy;
    if (r_rf_wen) w_busy_nxt[r_rf_waddr] = 1'b0;
    if (w_ex_fire && w_ex_load && (ex_rd != 5'd0)) w_busy_nxt[ex_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd       <= 5'd0;
      r_f3       <= 3'd0;
      r_alo      <= 3'd0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 64'd0;
      r_ld_busy  <= 32'd0;
      r_retire   <= 1'b0;
    end else begin
      r_rf_wen  <= 1'b0;
      r_retire  <= 1'b0;
      r_ld_busy <= w_busy_nxt;
      if (w_ex_fire) begin
        if (w_ex_load) begin
          r_rd  <= ex_rd;
          r_f3  <= ex_ld_funct3;
          r_alo <= ex_addr_lo;
        end else begin
          r_rf_wen   <= (ex_wb_sel != 2'b00) && (ex_rd != 5'd0);
          r_rf_waddr <= ex_rd;
          r_rf_wdata <= ex_result;
          r_retire   <= 1'b1;
        end
      end else if (w_mem_fire) begin
        r_rf_wen   <= (r_rd != 5'd0);
        r_rf_waddr <= r_rd;
        r_rf_wdata <= w_ld_val;
        r_retire   <= 1'b1;
      end
    end
  end

  assign rf_wen   = r_rf_wen;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign ld_busy  = r_ld_busy;
  assign retire   = r_retire;

endmodule

// File: tb/tb_ysyx_22041461_wbu.sv
// tb/tb_ysyx_22041461_wbu.sv - scoreboard bench for the writeback unit
module tb_ysyx_22041461_wbu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [1:0]  ex_wb_sel;
  logic [4:0]  ex_rd;
  logic [63:0] ex_result;
  logic [2:0]  ex_ld_funct3;
  logic [2:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [63:0] mem_rdata;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [31:0] ld_busy;
  logic        retire;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];

  ysyx_22041461_wbu dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wb_sel(ex_wb_sel), .ex_rd(ex_rd),
    .ex_result(ex_result), .ex_ld_funct3(ex_ld_funct3), .ex_addr_lo(ex_addr_lo),
    .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ld_busy(ld_busy), .retire(retire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte-wise reference for load formatting.
  function automatic logic [63:0] model(input logic [2:0] f3, input logic [2:0] alo, input logic [63:0] d);
    int n;
    int idx;
    logic [63:0] v;
    logic sgn;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      idx = int'(alo) + i;
      if (idx < 8) v[i*8 +: 8] = d[idx*8 +: 8];
    end
    if (!f3[2] && n < 8) begin
      sgn = v[n*8-1];
      for (int j = n*8; j < 64; j++) v[j] = sgn;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && retire === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_retire", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rf_wen", 64'(rf_wen), 64'(e.wen));
        if (e.wen) begin
          chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end else if (rst === 1'b1 && rf_wen === 1'b1) begin
      chk("wen_without_retire", 64'd1, 64'd0);
    end
  end

  task automatic send_ex(input logic [1:0] sel, input logic [4:0] rd, input logic [63:0] res,
                         input logic [2:0] f3, input logic [2:0] alo,
                         input bit push, input logic wen, input logic [63:0] data);
    int n;
    exp_t e;
    @(negedge clk);
    ex_valid = 1'b1; ex_wb_sel = sel; ex_rd = rd; ex_result = res;
    ex_ld_funct3 = f3; ex_addr_lo = alo;
    n = 0;
    while (!ex_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ex_ready) chk("ready_timeout", 64'd0, 64'd1);
    if (push) begin
      e.wen = wen; e.addr = rd; e.data = data;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 ex_valid = 1'b0;
  endtask

  task automatic mem_resp(input logic [63:0] d, input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = d;
    @(posedge clk);
    #1 mem_rvalid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] alo,
                         input logic [63:0] d, input logic [63:0] exp, input int delay);
    send_ex(2'b10, rd, 64'd0, f3, alo, 1'b1, (rd != 5'd0), exp);
    mem_resp(d, delay);
  endtask

  initial begin
    rst = 1'b0; ex_valid = 1'b0; ex_wb_sel = 2'b00; ex_rd = 5'd0; ex_result = 64'd0;
    ex_ld_funct3 = 3'd0; ex_addr_lo = 3'd0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    #2;
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_rf_wdata", rf_wdata, 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_ld_busy", 64'(ld_busy), 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_mem_rready", 64'(mem_rready), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset while a load to x5 is outstanding.
    send_ex(2'b10, 5'd5, 64'd0, 3'b011, 3'd0, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    chk("midload_busy5", 64'(ld_busy[5]), 64'd1);
    chk("midload_mem_rready", 64'(mem_rready), 64'd1);
    chk("midload_ex_ready", 64'(ex_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("midload_rst_busy", 64'(ld_busy), 64'd0);
    chk("midload_rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("midload_rst_mem_rready", 64'(mem_rready), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 64'h1234;
    repeat (2) begin
      @(negedge clk);
      chk("stray_rvalid_wen", 64'(rf_wen), 64'd0);
      chk("stray_rvalid_retire", 64'(retire), 64'd0);
    end
    mem_rvalid = 1'b0;

    // Back-to-back ALU writes.
    send_ex(2'b01, 5'd3, 64'h11, 3'd0, 3'd0, 1'b1, 1'b1, 64'h11);
    send_ex(2'b01, 5'd4, 64'h22, 3'd0, 3'd0, 1'b1, 1'b1, 64'h22);
    #3;
    chk("b2b_second_wen", 64'(rf_wen), 64'd1);
    send_ex(2'b11, 5'd31, 64'hCAFE_F00D_0000_0001, 3'd0, 3'd0, 1'b1, 1'b1, 64'hCAFE_F00D_0000_0001);

    // LB / LBU.
    do_load(5'd7, 3'b000, 3'd2, 64'h0000_0000_0080_0000, 64'hFFFF_FFFF_FFFF_FF80, 0);
    do_load(5'd7, 3'b100, 3'd2, 64'h0000_0000_0080_0000, 64'h0000_0000_0000_0080, 0);

    // LW / LWU at addr_lo 4.
    do_load(5'd8, 3'b010, 3'd4, 64'h8000_0001_DEAD_BEEF, 64'hFFFF_FFFF_8000_0001, 1);
    do_load(5'd8, 3'b110, 3'd4, 64'h8000_0001_DEAD_BEEF, 64'h0000_0000_8000_0001, 2);

    // Misaligned LH at addr_lo 7: upper byte reads as zero.
    do_load(5'd12, 3'b001, 3'd7, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 0);

    // Stall: load x9, next instruction held valid during the wait.
    send_ex(2'b10, 5'd9, 64'd0, 3'b011, 3'd0, 1'b1, 1'b1, 64'h0102_0304_0506_0708);
    ex_valid = 1'b1; ex_wb_sel = 2'b01; ex_rd = 5'd10; ex_result = 64'h99;
    sb.push_back('{wen: 1'b1, addr: 5'd10, data: 64'h99});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ex_ready", 64'(ex_ready), 64'd0);
      chk("stall_busy9", 64'(ld_busy[9]), 64'd1);
    end
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'h0102_0304_0506_0708;
    @(posedge clk);
    #1 mem_rvalid = 1'b0;
    @(negedge clk);
    chk("wcycle_busy9", 64'(ld_busy[9]), 64'd1);
    chk("wcycle_ex_ready", 64'(ex_ready), 64'd1);
    chk("wcycle_rf_wen", 64'(rf_wen), 64'd1);
    @(posedge clk);
    #1 ex_valid = 1'b0;
    @(negedge clk);
    chk("after_busy9", 64'(ld_busy[9]), 64'd0);
    chk("after_retire_alu", 64'(retire), 64'd1);

    // x0 and no-writeback instructions retire without writing.
    send_ex(2'b01, 5'd0, 64'h55, 3'd0, 3'd0, 1'b1, 1'b0, 64'd0);
    send_ex(2'b00, 5'd6, 64'h66, 3'd0, 3'd0, 1'b1, 1'b0, 64'd0);
    send_ex(2'b10, 5'd0, 64'd0, 3'b010, 3'd0, 1'b1, 1'b0, 64'd0);
    @(negedge clk);
    chk("lw_x0_busy", 64'(ld_busy), 64'd0);
    mem_resp(64'hFFFF_FFFF_FFFF_FFFF, 0);

    // Random loads and ALU ops against the byte-wise model.
    for (int k = 0; k < 24; k++) begin
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [2:0]  alo;
      logic [63:0] d;
      rd  = 5'($urandom_range(1, 31));
      f3  = 3'($urandom_range(0, 7));
      alo = 3'($urandom_range(0, 7));
      d   = {32'($urandom), 32'($urandom)};
      if (k % 3 == 0) send_ex(2'b01, rd, d, 3'd0, 3'd0, 1'b1, 1'b1, d);
      else do_load(rd, f3, alo, d, model(f3, alo, d), k % 4);
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_busy", 64'(ld_busy), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
